swin_ctrl: RTL and testbench
============================

// Module: swin_ctrl
// PURPOSE
//  Sequencer for the 3-line sliding-window BRAM buffer. Walks the config RAM, one entry per image segment.
//  Accepts 128-bit pixel beats and generates per-line BRAM write enables, a shared column address and line rotation.
//  Asserts window-valid once two prior rows are buffered. Sits between the pixel stream source and swin_wrap datapath.
// PARAMETERS
//  CONF_DATA_WIDTH  19  config word width: [18]=last, [17:9]=rows, [8:0]=words per row
//  CONF_ADDR_WIDTH  9   config RAM / line-BRAM address width
//  NUM_LINES        3   line BRAMs in rotation (fixed 3; other values unsupported)
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   synchronous reset, active low
//  start          in   1   1-cycle pulse; begins program at conf addr 0
//  busy           out  1   high from start accept until done
//  done           out  1   1-cycle pulse after last entry completes
//  err            out  1   sticky; set on rows==0 or words==0 entry; cleared by start
//  conf_rd_en     out  1   config RAM read strobe
//  conf_addr      out  9   config RAM address
//  conf_data      in   19  config RAM read data, valid 1 cycle after conf_rd_en
//  data_in_vld    in   1   pixel beat valid
//  data_in_rdy    out  1   beat accepted when vld&rdy
//  bram_wr_en     out  3   one-hot write enable, line BRAM holding newest row
//  bram_addr      out  9   column address: write to newest line and read of both older lines, same cycle
//  line_sel       out  2   index of newest line, aligned with data_out_vld
//  data_out_vld   out  1   window column valid (registered, 1 cycle after accepted beat)
// BEHAVIOUR
//  Reset: state IDLE; busy, done, err, conf_rd_en, data_in_rdy, bram_wr_en, data_out_vld = 0;
//   conf_addr, bram_addr, line_sel = 0; row/col/line counters = 0.
//  FSM: IDLE -start-> FETCH (conf_rd_en=1) -> LOAD (capture conf_data) -> RUN -> FETCH | DONE -> IDLE.
//  start ignored unless IDLE. start clears err, conf_addr, global row count, newest-line index to 0.
//  LOAD: rows==0 or words==0 -> err=1, go DONE. No beats are accepted for that entry.
//  RUN: data_in_rdy=1. Each accepted beat: bram_wr_en=1<<wline, bram_addr=col, col++.
//  Beat with col==words-1: col=0, row++, wline=(wline==2)?0:wline+1 (wrap).
//  Last beat of last row of entry: -> DONE if last flag or conf_addr==511, else conf_addr++ and -> FETCH.
//  Inter-entry bubble: exactly 2 cycles with data_in_rdy=0 (FETCH, LOAD).
//  Latency: start seen in cycle 0 -> rdy first high in cycle 3.
//  Window: data_out_vld=1 in cycle after accepted beat iff global row >=2. Global row counts across entries, saturates at 511.
//   line_sel = wline of that beat; older lines = line_sel-1, line_sel-2 mod 3. BRAM read latency 1 matches.
//  data_in_vld while rdy=0: beat dropped, no state change.
//  done: 1-cycle pulse in DONE; busy drops the same cycle.
//  rst_n low mid-frame: all state returns to reset values next edge; partial rows discarded.
//  Counters are 9 bits; col < words <= 511, so col never overflows.
// CONFIGURATION
//  SWIN_CTRL_STAT_EN defined: adds outputs stat_beats[31:0] (accepted beats) and stat_drops[15:0]
//   (vld&!rdy while busy, saturating). Both cleared by start and reset.
//  Macro undefined: those ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//  swin_ctrl_pkg: FSM state encoding (IDLE, FETCH, LOAD, RUN, DONE), conf field bit positions
//   (LAST_BIT=18, ROWS_MSB/LSB=17/9, WORDS_MSB/LSB=8/0), NUM_LINES.
//  Sub-module swin_line_rot: mod-3 newest-line counter with one-hot wr_en decode and line_sel output register.
// TESTING
//  1. Single entry {last=1,rows=4,words=8}, continuous vld -> 32 beats, wr_en cycles 001,010,100,001;
//     data_out_vld on beats 17..32 only; done at beat 32 +1.
//  2. Two entries {0,2,4},{1,3,4} -> rdy low exactly 2 cycles between entry 0 and 1; row count carries over,
//     so out_vld begins at beat 9.
//  3. Entry {1,0,5} -> err=1, done pulse, no wr_en; new start clears err.
//  4. vld toggled 1010 with rdy low in bubble -> dropped beats cause no col change; STAT_EN build reports stat_drops=2.
//  5. rst_n low at beat 10 of a {1,4,8} frame -> next cycle all outputs at reset values; restart reproduces test 1.
//  6. 512 entries, none with last -> terminates after conf_addr 511, done asserted, conf_addr does not wrap.

Source files
------------

// File: rtl/swin_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | swin_ctrl_pkg                                                            |
// | Shared constants, config-word field positions and FSM encoding.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package swin_ctrl_pkg;

    localparam int CONF_DATA_WIDTH = 19;
    localparam int CONF_ADDR_WIDTH = 9;
    localparam int NUM_LINES       = 3;

    localparam int LAST_BIT  = 18;
    localparam int ROWS_MSB  = 17;
    localparam int ROWS_LSB  = 9;
    localparam int WORDS_MSB = 8;
    localparam int WORDS_LSB = 0;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_LOAD  = 3'd2;
    localparam state_t S_RUN   = 3'd3;
    localparam state_t S_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/swin_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | swin_ctrl_if                                                             |
// | Config-RAM, pixel-stream and line-BRAM control bundle of swin_ctrl.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface swin_ctrl_if;
    import swin_ctrl_pkg::*;

    logic                       conf_rd_en;
    logic [CONF_ADDR_WIDTH-1:0] conf_addr;
    logic [CONF_DATA_WIDTH-1:0] conf_data;
    logic                       data_in_vld;
    logic                       data_in_rdy;
    logic [NUM_LINES-1:0]       bram_wr_en;
    logic [CONF_ADDR_WIDTH-1:0] bram_addr;
    logic [1:0]                 line_sel;
    logic                       data_out_vld;

    modport master (
        output conf_rd_en, conf_addr,
        input  conf_data,
        input  data_in_vld,
        output data_in_rdy,
        output bram_wr_en, bram_addr, line_sel, data_out_vld
    );

    modport slave (
        input  conf_rd_en, conf_addr,
        output conf_data,
        output data_in_vld,
        input  data_in_rdy,
        input  bram_wr_en, bram_addr, line_sel, data_out_vld
    );

endinterface
`default_nettype wire

// File: rtl/swin_line_rot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | swin_line_rot                                                            |
// | Mod-3 newest-line counter, one-hot write-enable decode, line_sel reg.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module swin_line_rot
    import swin_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 beat,
    input  logic                 row_end,
    output logic [NUM_LINES-1:0] wr_en,
    output logic [1:0]           line_sel
);
    logic [1:0] r_wline;
    logic [1:0] r_line_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wline    <= 2'd0;
            r_line_sel <= 2'd0;
        end else begin
            if (clr) begin
                r_wline <= 2'd0;
            end else if (beat && row_end) begin
                r_wline <= (r_wline == 2'd2) ? 2'd0 : r_wline + 2'd1;
            end
            // Registered so it lines up with the one-cycle BRAM read data.
            if (beat) begin
                r_line_sel <= r_wline;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_LINES; g++) begin : g_wr_en
            assign wr_en[g] = beat && (r_wline == 2'(g));
        end
    endgenerate

    assign line_sel = r_line_sel;

endmodule
`default_nettype wire

// File: rtl/swin_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | swin_ctrl                                                                |
// | 3-line sliding-window sequencer: walks config RAM, paces pixel beats,    |
// | drives line-BRAM enables/address. Optional SWIN_CTRL_STAT_EN counters.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module swin_ctrl
    import swin_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
`ifdef SWIN_CTRL_STAT_EN
    output logic [31:0] stat_beats,
    output logic [15:0] stat_drops,
`endif
    swin_ctrl_if.master bus
);
    localparam logic [CONF_ADDR_WIDTH-1:0] c_addr_max = '1;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_err;
    logic                       r_last;
    logic                       r_out_vld;
    logic [CONF_ADDR_WIDTH-1:0] r_conf_addr;
    logic [CONF_ADDR_WIDTH-1:0] r_rows;
    logic [CONF_ADDR_WIDTH-1:0] r_words;
    logic [CONF_ADDR_WIDTH-1:0] r_col;
    logic [CONF_ADDR_WIDTH-1:0] r_row;
    logic [CONF_ADDR_WIDTH-1:0] r_grow;
    logic                       w_busy;
    logic                       w_done;
    logic                       w_rd_en;
    logic                       w_rdy;
    logic                       w_accept;
    logic                       w_start_ok;
    logic                       w_col_end;
    logic                       w_entry_end;
    logic                       w_final;
    logic                       w_conf_bad;

    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_accept    = w_rdy && bus.data_in_vld;
    assign w_col_end   = (r_col == r_words - 9'd1);
    assign w_entry_end = w_col_end && (r_row == r_rows - 9'd1);
    assign w_final     = r_last || (r_conf_addr == c_addr_max);
    assign w_conf_bad  = (bus.conf_data[ROWS_MSB:ROWS_LSB] == '0) ||
                         (bus.conf_data[WORDS_MSB:WORDS_LSB] == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_rd_en     = 1'b0;
        w_rdy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_busy      = 1'b1;
                w_rd_en     = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_busy      = 1'b1;
                w_state_nxt = w_conf_bad ? S_DONE : S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_rdy  = 1'b1;
                if (bus.data_in_vld && w_entry_end) begin
                    w_state_nxt = w_final ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err       <= 1'b0;
            r_last      <= 1'b0;
            r_out_vld   <= 1'b0;
            r_conf_addr <= '0;
            r_rows      <= '0;
            r_words     <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_grow      <= '0;
        end else begin
            if (w_start_ok) begin
                r_err       <= 1'b0;
                r_conf_addr <= '0;
                r_grow      <= '0;
            end
            if (r_state == S_LOAD) begin
                r_last  <= bus.conf_data[LAST_BIT];
                r_rows  <= bus.conf_data[ROWS_MSB:ROWS_LSB];
                r_words <= bus.conf_data[WORDS_MSB:WORDS_LSB];
                r_col   <= '0;
                r_row   <= '0;
                if (w_conf_bad) r_err <= 1'b1;
            end
            if (w_accept) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= r_row + 9'd1;
                    if (r_grow != c_addr_max) r_grow <= r_grow + 9'd1;
                end else begin
                    r_col <= r_col + 9'd1;
                end
                if (w_entry_end && !w_final) begin
                    r_conf_addr <= r_conf_addr + 9'd1;
                end
            end
            // Window is complete only once two earlier rows sit in the other lines.
            r_out_vld <= w_accept && (r_grow >= 9'd2);
        end
    end

    swin_line_rot u_line_rot (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_start_ok),
        .beat     (w_accept),
        .row_end  (w_col_end),
        .wr_en    (bus.bram_wr_en),
        .line_sel (bus.line_sel)
    );

`ifdef SWIN_CTRL_STAT_EN
    logic [31:0] r_stat_beats;
    logic [15:0] r_stat_drops;

    always_ff @(posedge clk) begin
        if (!rst_n || w_start_ok) begin
            r_stat_beats <= '0;
            r_stat_drops <= '0;
        end else begin
            if (w_accept) r_stat_beats <= r_stat_beats + 32'd1;
            if (w_busy && bus.data_in_vld && !w_rdy && (r_stat_drops != 16'hFFFF)) begin
                r_stat_drops <= r_stat_drops + 16'd1;
            end
        end
    end

    assign stat_beats = r_stat_beats;
    assign stat_drops = r_stat_drops;
`endif

    assign busy             = w_busy;
    assign done             = w_done;
    assign err              = r_err;
    assign bus.conf_rd_en   = w_rd_en;
    assign bus.conf_addr    = r_conf_addr;
    assign bus.data_in_rdy  = w_rdy;
    assign bus.bram_addr    = r_col;
    assign bus.data_out_vld = r_out_vld;

endmodule
`default_nettype wire

// File: tb/tb_swin_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_swin_ctrl                                                             |
// | Scoreboard bench for swin_ctrl; honours SWIN_CTRL_STAT_EN when defined.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_swin_ctrl;

    typedef struct {
        logic [2:0] wr_en;
        logic [8:0] addr;
        logic [1:0] line;
        logic       ovld;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done, err;
`ifdef SWIN_CTRL_STAT_EN
    logic [31:0] stat_beats;
    logic [15:0] stat_drops;
`endif

    swin_ctrl_if bus ();

    swin_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
`ifdef SWIN_CTRL_STAT_EN
        .stat_beats (stat_beats),
        .stat_drops (stat_drops),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [18:0] conf_mem [512];
    always @(posedge clk) begin
        if (bus.conf_rd_en) bus.conf_data <= conf_mem[bus.conf_addr];
    end

    int    checks = 0;
    int    errors = 0;
    beat_t sb[$];
    bit    mon_en = 1'b0;
    logic  exp_ovld = 1'b0;
    bit    exp_chk_line = 1'b0;
    logic [1:0] exp_line = 2'd0;
    int    m_col, m_row, m_ent, m_wline, m_grow;

    function automatic logic [18:0] cw(input logic last, input int rows, input int words);
        return {last, 9'(rows), 9'(words)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pops one expectation per BRAM write and checks the registered window outputs next cycle.
    task automatic monitor;
        beat_t e;
        logic  nxt_ovld;
        bit    nxt_chk;
        logic [1:0] nxt_line;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (bus.data_out_vld !== exp_ovld) begin
                    errors++;
                    $display("FAIL out_vld @%0t: got %b expected %b", $time, bus.data_out_vld, exp_ovld);
                end
                if (exp_chk_line) begin
                    checks++;
                    if (bus.line_sel !== exp_line) begin
                        errors++;
                        $display("FAIL line_sel @%0t: got %0d expected %0d", $time, bus.line_sel, exp_line);
                    end
                end
                nxt_ovld = 1'b0;
                nxt_chk  = 1'b0;
                nxt_line = 2'd0;
                if (bus.bram_wr_en !== 3'b000) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write @%0t: got wr_en %b expected none", $time, bus.bram_wr_en);
                    end else begin
                        e = sb.pop_front();
                        if (bus.bram_wr_en !== e.wr_en || bus.bram_addr !== e.addr) begin
                            errors++;
                            $display("FAIL beat @%0t: got wr_en %b addr %0d expected wr_en %b addr %0d",
                                     $time, bus.bram_wr_en, bus.bram_addr, e.wr_en, e.addr);
                        end
                        nxt_ovld = e.ovld && rst_n;
                        nxt_chk  = rst_n;
                        nxt_line = e.line;
                    end
                end
                exp_ovld     = nxt_ovld;
                exp_chk_line = nxt_chk;
                exp_line     = nxt_line;
            end
        end
    endtask

    // vmode 0: vld always high; 1: vld high on even cycles counted from the start cycle.
    task automatic drive_frame(input int vmode, input int stop_after, input int max_cyc,
                               output int beats, output int rdy_first, output int last_beat,
                               output int done_at, output int bubble);
        beat_t       e;
        logic [18:0] ent;
        beats = 0; rdy_first = -1; last_beat = -1; done_at = -1; bubble = 0;
        m_col = 0; m_row = 0; m_ent = 0; m_wline = 0; m_grow = 0;
        start = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            if (c > 0) start = 1'b0;
            bus.data_in_vld = (vmode == 0) ? 1'b1 : (c % 2 == 0);
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            if (bus.data_in_rdy === 1'b1) begin
                if (rdy_first < 0) rdy_first = c;
            end else if (rdy_first >= 0) begin
                bubble++;
            end
            if (bus.data_in_vld && bus.data_in_rdy === 1'b1) begin
                e.wr_en = 3'(1 << m_wline);
                e.addr  = 9'(m_col);
                e.line  = 2'(m_wline);
                e.ovld  = (m_grow >= 2);
                sb.push_back(e);
                beats++;
                last_beat = c;
                ent = conf_mem[m_ent];
                m_col++;
                if (m_col == int'(ent[8:0])) begin
                    m_col = 0;
                    m_row++;
                    if (m_grow < 511) m_grow++;
                    m_wline = (m_wline == 2) ? 0 : m_wline + 1;
                    if (m_row == int'(ent[17:9])) begin
                        m_row = 0;
                        m_ent++;
                    end
                end
                if (beats == stop_after) begin
                    tick;
                    bus.data_in_vld = 1'b0;
                    start = 1'b0;
                    return;
                end
            end
            tick;
        end
        bus.data_in_vld = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset;
        logic [28:0] obs;
        rst_n = 1'b0;
        start = 1'b0;
        bus.data_in_vld = 1'b0;
        repeat (3) tick;
        obs = {busy, done, err, bus.conf_rd_en, bus.data_in_rdy, bus.bram_wr_en,
               bus.bram_addr, bus.line_sel, bus.data_out_vld, bus.conf_addr};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", obs);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick;
    endtask

    task automatic test_single(input string tag);
        int beats, rf, lb, da, bub;
        conf_mem[0] = cw(1'b1, 4, 8);
        drive_frame(0, -1, 100, beats, rf, lb, da, bub);
        checks++;
        if (beats !== 32) begin errors++; $display("FAIL %s_beats: got %0d expected 32", tag, beats); end
        checks++;
        if (rf !== 3) begin errors++; $display("FAIL %s_latency: got %0d expected 3", tag, rf); end
        checks++;
        if (da !== lb + 1 || lb < 0) begin
            errors++; $display("FAIL %s_done_at: got %0d expected %0d", tag, da, lb + 1);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b expected 0", tag, busy); end
        tick;
        checks++;
        if (done !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL %s_after_done: got done %b pending %0d expected 0 0", tag, done, sb.size());
        end
    endtask

    task automatic test_two_entries;
        int beats, rf, lb, da, bub;
        conf_mem[0] = cw(1'b0, 2, 4);
        conf_mem[1] = cw(1'b1, 3, 4);
        drive_frame(0, -1, 100, beats, rf, lb, da, bub);
        checks++;
        if (beats !== 20) begin errors++; $display("FAIL two_beats: got %0d expected 20", beats); end
        checks++;
        if (bub !== 2) begin errors++; $display("FAIL two_bubble: got %0d expected 2", bub); end
        checks++;
        if (da !== lb + 1 || lb < 0) begin errors++; $display("FAIL two_done_at: got %0d expected %0d", da, lb + 1); end
        tick;
    endtask

    task automatic test_err;
        int beats, rf, lb, da, bub;
        logic [18:0] bad [2];
        bad[0] = cw(1'b1, 0, 5);
        bad[1] = cw(1'b1, 3, 0);
        for (int i = 0; i < 2; i++) begin
            conf_mem[0] = bad[i];
            drive_frame(0, -1, 20, beats, rf, lb, da, bub);
            checks++;
            if (beats !== 0 || da !== 3) begin
                errors++; $display("FAIL err%0d_frame: got beats %0d done_at %0d expected 0 3", i, beats, da);
            end
            checks++;
            if (err !== 1'b1) begin errors++; $display("FAIL err%0d_flag: got %b expected 1", i, err); end
            tick; tick;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL err%0d_sticky: got err %b busy %b expected 1 0", i, err, busy);
            end
        end
        conf_mem[0] = cw(1'b1, 1, 1);
        drive_frame(0, -1, 20, beats, rf, lb, da, bub);
        checks++;
        if (err !== 1'b0 || beats !== 1) begin
            errors++; $display("FAIL err_cleared: got err %b beats %0d expected 0 1", err, beats);
        end
        tick;
    endtask

    task automatic test_drops;
        int beats, rf, lb, da, bub;
        conf_mem[0] = cw(1'b0, 1, 2);
        conf_mem[1] = cw(1'b1, 1, 2);
        drive_frame(1, -1, 50, beats, rf, lb, da, bub);
        checks++;
        if (beats !== 4 || bub !== 2) begin
            errors++; $display("FAIL drops_frame: got beats %0d bubble %0d expected 4 2", beats, bub);
        end
        checks++;
        if (da !== 13) begin errors++; $display("FAIL drops_done_at: got %0d expected 13", da); end
`ifdef SWIN_CTRL_STAT_EN
        checks++;
        if (stat_drops !== 16'd2 || stat_beats !== 32'd4) begin
            errors++; $display("FAIL stat: got drops %0d beats %0d expected 2 4", stat_drops, stat_beats);
        end
`endif
        tick;
    endtask

    task automatic test_reset_mid;
        int beats, rf, lb, da, bub;
        logic [28:0] obs;
        conf_mem[0] = cw(1'b1, 4, 8);
        drive_frame(0, 9, 100, beats, rf, lb, da, bub);
        rst_n = 1'b0;
        tick;
        obs = {busy, done, err, bus.conf_rd_en, bus.data_in_rdy, bus.bram_wr_en,
               bus.bram_addr, bus.line_sel, bus.data_out_vld, bus.conf_addr};
        checks++;
        if (obs !== '0 || beats !== 9) begin
            errors++; $display("FAIL mid_reset: got %h beats %0d expected 0 9", obs, beats);
        end
        rst_n = 1'b1;
        tick;
        test_single("restart");
    endtask

    task automatic test_max_entries;
        int beats, rf, lb, da, bub;
        for (int i = 0; i < 512; i++) conf_mem[i] = cw(1'b0, 1, 1);
        drive_frame(0, -1, 2000, beats, rf, lb, da, bub);
        checks++;
        if (beats !== 512 || bub !== 1022) begin
            errors++; $display("FAIL max_frame: got beats %0d bubble %0d expected 512 1022", beats, bub);
        end
        checks++;
        if (da !== lb + 1 || lb < 0) begin errors++; $display("FAIL max_done_at: got %0d expected %0d", da, lb + 1); end
        checks++;
        if (bus.conf_addr !== 9'd511) begin errors++; $display("FAIL max_addr: got %0d expected 511", bus.conf_addr); end
        tick; tick;
        checks++;
        if (bus.conf_addr !== 9'd511 || busy !== 1'b0) begin
            errors++; $display("FAIL max_hold: got addr %0d busy %b expected 511 0", bus.conf_addr, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) conf_mem[i] = '0;
        fork
            monitor();
        join_none
        test_reset;
        test_single("single");
        test_two_entries;
        test_err;
        test_drops;
        test_reset_mid;
        test_max_entries;
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
